// File: rtl/clic_arb.sv
// Core-local interrupt controller: per-source pending/enable/attr/ctl state,
// level/priority arbitration against a threshold, and a one-cycle bus slave.
package clic_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;
  } mem_out_type;
endpackage

// One interrupt source: ip/ie/attr/ctl storage and pending-bit update rules.
module clic_src #(
  parameter int INTCTLBITS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       irq_s,
  input  logic       irq_d,
  input  logic       wr_en,
  input  logic [3:0] wstrb,
  input  logic       ip_wd,
  input  logic       ie_wd,
  input  logic [4:0] attr_wd,   // {mode[1:0], trig[1:0], shv}
  input  logic [7:0] ctl_wd,
  input  logic       ack_clr,
  output logic       ip,
  output logic       ie,
  output logic       shv,
  output logic [1:0] trig,
  output logic [1:0] mode,
  output logic [7:0] ctl
);
  // Unimplemented low ctl bits read back as 1.
  localparam logic [7:0] CTL_ONES = 8'hFF >> INTCTLBITS;

  logic edge_set;
  assign edge_set = trig[1] ? (irq_d & ~irq_s) : (~irq_d & irq_s);

  // Register writes; in edge mode hw set beats sw write beats ack clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      ip   <= 1'b0;
      ie   <= 1'b0;
      shv  <= 1'b0;
      trig <= 2'b00;
      mode <= 2'b00;
      ctl  <= 8'hFF;
    end else begin
      if (wr_en && wstrb[1]) ie <= ie_wd;
      if (wr_en && wstrb[2]) {mode, trig, shv} <= attr_wd;
      if (wr_en && wstrb[3]) ctl <= ctl_wd | CTL_ONES;
      if (!trig[0])                ip <= irq_s;
      else if (edge_set)           ip <= 1'b1;
      else if (wr_en && wstrb[0])  ip <= ip_wd;
      else if (ack_clr)            ip <= 1'b0;
    end
  end
endmodule

module clic_arb
  import clic_pkg::*;
#(
  parameter int NUM_IRQ    = 64,
  parameter int INTCTLBITS = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  mem_in_type         clic_in,
  output mem_out_type        clic_out,
  input  logic [NUM_IRQ-1:0] clic_irpt,
  input  logic               clic_ack,
  output logic               clic_meip,
  output logic [11:0]        clic_meid,
  output logic [7:0]         clic_mlevel,
  output logic               clic_shv
);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0]       irq_s, irq_d, ip, ie, shv, src_wr, src_ack;
  logic [NUM_IRQ-1:0][1:0]  trig, mode;
  logic [NUM_IRQ-1:0][7:0]  ctl;
  logic [3:0]               nlbits;
  logic [7:0]               mintthresh;

  logic        wr, is_cfg, is_info, is_th, is_src, mapped;
  logic [29:0] a, off;
  logic [IW-1:0] idx;
  logic [31:0] rd_n;
  logic        unused_bits;

  assign unused_bits = ^{clic_in.mem_addr[1:0], clic_in.mem_wdata[15:9],
                         clic_in.mem_wdata[21:19]};

  // Two-stage sampling of the raw lines for level copy and edge detect.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_s <= '0;
      irq_d <= '0;
    end else begin
      irq_s <= clic_irpt;
      irq_d <= irq_s;
    end
  end

  // Address decode and read-data mux for the current request.
  always_comb begin
    wr      = clic_in.mem_valid && (clic_in.mem_wstrb != 4'b0000);
    a       = clic_in.mem_addr[31:2];
    off     = a - 30'h400;
    is_cfg  = (a == 30'd0);
    is_info = (a == 30'd1);
    is_th   = (a == 30'd2);
    is_src  = (a >= 30'h400) && (off < 30'(NUM_IRQ));
    idx     = off[IW-1:0];
    mapped  = is_cfg | is_info | is_th | is_src;
    rd_n    = '0;
    if (is_cfg)       rd_n = {27'd0, nlbits, 1'b0};
    else if (is_info) rd_n = (32'(INTCTLBITS) << 21) | 32'(NUM_IRQ);
    else if (is_th)   rd_n = {24'd0, mintthresh};
    else if (is_src)  rd_n = {ctl[idx], mode[idx], 3'b000, trig[idx], shv[idx],
                              7'd0, ie[idx], 7'd0, ip[idx]};
  end

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : g_src
      assign src_wr[g]  = wr && is_src && (idx == IW'(g));
      assign src_ack[g] = clic_ack && clic_meip && (g != 0) && (clic_meid == 12'(g));
      clic_src #(.INTCTLBITS(INTCTLBITS)) u_src (
        .clock   (clock),
        .reset   (reset),
        .irq_s   (irq_s[g]),
        .irq_d   (irq_d[g]),
        .wr_en   (src_wr[g]),
        .wstrb   (clic_in.mem_wstrb),
        .ip_wd   (clic_in.mem_wdata[0]),
        .ie_wd   (clic_in.mem_wdata[8]),
        .attr_wd ({clic_in.mem_wdata[23:22], clic_in.mem_wdata[18:16]}),
        .ctl_wd  (clic_in.mem_wdata[31:24]),
        .ack_clr (src_ack[g]),
        .ip      (ip[g]),
        .ie      (ie[g]),
        .shv     (shv[g]),
        .trig    (trig[g]),
        .mode    (mode[g]),
        .ctl     (ctl[g])
      );
    end
  endgenerate

  // Bus response one cycle after the request; global registers written here.
  always_ff @(posedge clock) begin
    if (reset) begin
      clic_out   <= '0;
      nlbits     <= 4'd0;
      mintthresh <= 8'd0;
    end else begin
      clic_out.mem_ready <= clic_in.mem_valid;
      clic_out.mem_error <= clic_in.mem_valid && !mapped;
      clic_out.mem_rdata <= (clic_in.mem_valid && mapped) ? rd_n : 32'd0;
      if (wr && is_cfg && clic_in.mem_wstrb[0]) nlbits     <= clic_in.mem_wdata[4:1];
      if (wr && is_th  && clic_in.mem_wstrb[0]) mintthresh <= clic_in.mem_wdata[7:0];
    end
  end

  logic [3:0]  n;
  logic [7:0]  lv, pr, bl, bp;
  logic [11:0] bid;
  logic        found, bshv;

  // Arbitration: max level, then max prio, then lowest id (strict > keeps first).
  always_comb begin
    n     = (nlbits > 4'd8) ? 4'd8 : nlbits;
    found = 1'b0;
    bl    = 8'd0;
    bp    = 8'd0;
    bid   = 12'd0;
    bshv  = 1'b0;
    lv    = 8'd0;
    pr    = 8'd0;
    for (int i = 1; i < NUM_IRQ; i++) begin
      lv = ctl[i] | (8'hFF >> n);
      pr = (ctl[i] << n) | ~(8'hFF << n);
      if (ip[i] && ie[i] && (!found || lv > bl || (lv == bl && pr > bp))) begin
        found = 1'b1;
        bl    = lv;
        bp    = pr;
        bid   = 12'(i);
        bshv  = shv[i];
      end
    end
  end

  // Registered core-facing outputs, gated by the threshold.
  always_ff @(posedge clock) begin
    if (reset || !(found && bl > mintthresh)) begin
      clic_meip   <= 1'b0;
      clic_meid   <= 12'd0;
      clic_mlevel <= 8'd0;
      clic_shv    <= 1'b0;
    end else begin
      clic_meip   <= 1'b1;
      clic_meid   <= bid;
      clic_mlevel <= bl;
      clic_shv    <= bshv;
    end
  end
endmodule

// File: tb/tb_clic_arb.sv
// Directed bench for clic_arb: bus map, arbitration, edge/ack, threshold, reset.
module tb_clic_arb;
  import clic_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  mem_in_type  clic_in;
  mem_out_type clic_out;
  logic [63:0] clic_irpt;
  logic        clic_ack;
  logic        clic_meip;
  logic [11:0] clic_meid;
  logic [7:0]  clic_mlevel;
  logic        clic_shv;

  int total = 0;
  int bad   = 0;

  clic_arb #(.NUM_IRQ(64), .INTCTLBITS(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .clic_in     (clic_in),
    .clic_out    (clic_out),
    .clic_irpt   (clic_irpt),
    .clic_ack    (clic_ack),
    .clic_meip   (clic_meip),
    .clic_meid   (clic_meid),
    .clic_mlevel (clic_mlevel),
    .clic_shv    (clic_shv)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One bus request; returns sampled just after the response edge.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd, output logic err, output logic rdy);
    clic_in.mem_valid = 1'b1;
    clic_in.mem_addr  = addr;
    clic_in.mem_wdata = wd;
    clic_in.mem_wstrb = st;
    cyc(1);
    rd  = clic_out.mem_rdata;
    err = clic_out.mem_error;
    rdy = clic_out.mem_ready;
    clic_in.mem_valid = 1'b0;
    clic_in.mem_wstrb = 4'b0000;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic err, rdy;
    bus(addr, 32'd0, 4'b0000, rd, err, rdy);
    chk({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_data"}, rd, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] rd;
    logic err, rdy;
    bus(addr, wd, st, rd, err, rdy);
    chk("wr_rdy_err", {30'd0, rdy, err}, 32'd2);
  endtask

  initial begin
    logic [31:0] rd;
    logic err, rdy;
    reset     = 1'b1;
    clic_in   = '0;
    clic_irpt = '0;
    clic_ack  = 1'b0;
    cyc(2);
    reset = 1'b0;

    // Reset state
    chk("rst_out", {clic_meip, clic_shv, clic_mlevel, clic_meid}, 32'd0);
    chk("rst_bus", {clic_out.mem_ready, clic_out.mem_error}, 32'd0);
    chk("rst_rdata", clic_out.mem_rdata, 32'd0);

    // Info register and single-cycle ready
    rd_chk("info", 32'h4, 32'h0100_0040);
    cyc(1);
    chk("ready_drop", {31'd0, clic_out.mem_ready}, 32'd0);

    // Unmapped addresses
    bus(32'h800, 32'd0, 4'b0000, rd, err, rdy);
    chk("unmap_rd", {rdy, err, 30'd0}, 32'hC000_0000);
    chk("unmap_rdata", rd, 32'd0);
    bus(32'h800, 32'hFFFF_FFFF, 4'b1111, rd, err, rdy);
    chk("unmap_wr", {rdy, err, 30'd0}, 32'hC000_0000);
    rd_chk("cfg0", 32'h0, 32'd0);
    rd_chk("thr0", 32'h8, 32'd0);
    bus(32'h1100, 32'd0, 4'b0000, rd, err, rdy);
    chk("past_last", {30'd0, rdy, err}, 32'd3);
    rd_chk("last_src", 32'h10FC, 32'hFF00_0000);

    // Irq 5 level mode, nlbits=8, ctl=0x80
    wr(32'h0, 32'h10, 4'b0001);
    rd_chk("cfg8", 32'h0, 32'h10);
    wr(32'h1014, 32'h8000_0100, 4'b1010);
    clic_irpt[5] = 1'b1;
    cyc(2);
    chk("irq5_early", {31'd0, clic_meip}, 32'd0);
    cyc(1);
    chk("irq5_win", {clic_meip, clic_shv, 2'b00, clic_meid, 8'd0, clic_mlevel}, 32'h8005_0080);
    clic_irpt[5] = 1'b0;
    cyc(2);
    chk("irq5_hold", {31'd0, clic_meip}, 32'd1);
    cyc(1);
    chk("irq5_drop", {31'd0, clic_meip}, 32'd0);

    // Level-mode ip ignores software writes
    wr(32'h1014, 32'h1, 4'b0001);
    rd_chk("lvl_ipwr", 32'h1014, 32'h8000_0100);

    // Tie at level 0xC0 -> lowest id; raise irq 7
    wr(32'h100C, 32'hC000_0100, 4'b1010);
    wr(32'h101C, 32'hC000_0100, 4'b1010);
    clic_irpt[3] = 1'b1;
    clic_irpt[7] = 1'b1;
    cyc(3);
    chk("tie_id3", {clic_meip, 7'd0, clic_mlevel, 4'd0, clic_meid}, 32'h80C0_0003);
    wr(32'h101C, 32'hE000_0000, 4'b1000);
    cyc(1);
    chk("ctl_id7", {clic_meip, 7'd0, clic_mlevel, 4'd0, clic_meid}, 32'h80E0_0007);
    clic_irpt[3] = 1'b0;
    clic_irpt[7] = 1'b0;
    cyc(3);
    chk("tie_drop", {31'd0, clic_meip}, 32'd0);

    // Irq 9 rising-edge mode, ack clears it
    wr(32'h1024, 32'h0002_0100, 4'b0110);
    clic_irpt[9] = 1'b1;
    cyc(3);
    chk("edge9", {clic_meip, 7'd0, clic_mlevel, 4'd0, clic_meid}, 32'h80FF_0009);
    clic_ack = 1'b1;
    cyc(1);
    clic_ack = 1'b0;
    chk("ack_hold", {31'd0, clic_meip}, 32'd1);
    cyc(1);
    chk("ack_drop", {31'd0, clic_meip}, 32'd0);
    rd_chk("ack_ip0", 32'h1024, 32'hFF02_0100);

    // Software set, then a new edge arriving with the ack keeps ip set
    clic_irpt[9] = 1'b0;
    cyc(2);
    wr(32'h1024, 32'h1, 4'b0001);
    cyc(1);
    chk("swset9", {clic_meip, 19'd0, clic_meid}, 32'h8000_0009);
    clic_irpt[9] = 1'b1;
    cyc(1);
    clic_ack = 1'b1;
    cyc(1);
    clic_ack = 1'b0;
    cyc(1);
    chk("ack_vs_edge", {31'd0, clic_meip}, 32'd1);
    rd_chk("ack_vs_edge_ip", 32'h1024, 32'hFF02_0101);
    clic_ack = 1'b1;
    cyc(1);
    clic_ack = 1'b0;
    cyc(1);
    chk("ack2_drop", {31'd0, clic_meip}, 32'd0);
    wr(32'h1024, 32'h0, 4'b0010);

    // Threshold
    wr(32'h8, 32'h80, 4'b0001);
    wr(32'h1010, 32'h8001_0100, 4'b1110);
    clic_irpt[4] = 1'b1;
    cyc(4);
    chk("thr_block", {31'd0, clic_meip}, 32'd0);
    rd_chk("thr80", 32'h8, 32'h80);
    wr(32'h8, 32'h7F, 4'b0001);
    cyc(1);
    chk("thr_pass", {clic_meip, clic_shv, 6'd0, clic_mlevel, 4'd0, clic_meid}, 32'hC080_0004);

    // nlbits=2: level = ctl[7:6] followed by ones
    wr(32'h0, 32'h4, 4'b0001);
    cyc(1);
    chk("nl2_level", {24'd0, clic_mlevel}, 32'hBF);

    // Reset during a pending request
    clic_in.mem_valid = 1'b1;
    clic_in.mem_addr  = 32'h4;
    reset = 1'b1;
    cyc(1);
    clic_in.mem_valid = 1'b0;
    reset = 1'b0;
    chk("rst_mid", {29'd0, clic_out.mem_ready, clic_out.mem_error, clic_meip}, 32'd0);
    rd_chk("rst_thr", 32'h8, 32'd0);
    rd_chk("rst_src4", 32'h1010, 32'hFF00_0000);
    cyc(3);
    chk("rst_quiet", {31'd0, clic_meip}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clic_arb.md
Name: clic_arb

Overview:
- Parametrised second-generation core-local interrupt controller. Generic interrupt count and implemented intctl bits.
- Adds over the previous controller: a threshold register (mintthresh), a claim/acknowledge handshake that auto-clears edge-triggered pending bits, error responses on unmapped addresses, and registered level/priority/shv outputs.
- Sits on the memory bus beside the timer, and drives the core's machine external interrupt, id, level and shv.

Parameters:
- NUM_IRQ, 64, number of interrupt sources (2..4096). Id 0 is reserved and never wins.
- INTCTLBITS, 8, implemented upper bits of each 8-bit intctl (1..8). Lower 8-INTCTLBITS bits are hardwired to 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clic_in  in  mem_in_type  bus request: mem_valid, mem_addr, mem_wdata, mem_wstrb.
- clic_out  out  mem_out_type  bus response: mem_rdata, mem_ready, mem_error.
- clic_irpt  in  NUM_IRQ  raw interrupt lines, synchronous to clock.
- clic_ack  in  1  one-cycle pulse: core has taken the interrupt currently on clic_meid.
- clic_meip  out  1  interrupt request to core.
- clic_meid  out  12  winning interrupt id.
- clic_mlevel  out  8  effective level of the winner.
- clic_shv  out  1  selective-hardware-vectoring attribute of the winner.

Behaviour:
- Reset: all outputs 0, mem_ready 0, mem_error 0. cfg 0, mintthresh 0. All ip/ie/attr 0. All ctl = 8'hFF masked to the implemented bits. irpt history registers 0.
- Register map (word addresses; mem_addr[1:0] ignored):
  - 0x0000 cfg: nlbits[4:1] read/write, other bits read 0.
  - 0x0004 info, read-only: [30:25]=0, [24:21]=INTCTLBITS, [12:0]=NUM_IRQ.
  - 0x0008 mintthresh: [7:0] read/write.
  - 0x1000+4*i, i<NUM_IRQ: ip[0], ie[8], shv[16], trig[18:17], mode[23:22], ctl[31:24].
- Bus handshake: a request with mem_valid=1 produces mem_ready=1 for exactly one cycle, on the next cycle. mem_rdata is valid with mem_ready and is 0 otherwise.
  - Any unmapped address gets mem_ready=1 and mem_error=1, rdata 0, and the write has no effect.
  - A read is any request with wstrb=0. Back-to-back requests are accepted every cycle.
- Byte strobes on 0x1000 space: wstrb[0] writes ip, wstrb[1] writes ie, wstrb[2] writes attr, wstrb[3] writes ctl.
  - ip is software-writable only if trig[0]=1 (edge mode). In level mode the write is ignored.
  - ctl writes force the unimplemented low bits to 1.
- Input sampling: irq_s <= clic_irpt; irq_d <= irq_s.
  - trig[0]=0 (level mode): ip <= irq_s.
  - trig=01: ip set on irq_d=0 and irq_s=1.
  - trig=11: ip set on irq_d=1 and irq_s=0.
- Priority on the same cycle, set > software clear > ack clear.
- Ack: when clic_ack=1 and clic_meid=k>0 with trig[0]=1, ip[k] is cleared next cycle. Level-mode ip is unaffected. Ack with meip=0 is ignored.
- Level/priority decode, with n = min(nlbits, 8):
  - level = ctl[7:8-n] followed by 1s.
  - prio = ctl[7-n:0] followed by 1s. If n=8, prio = 8'hFF.
- Arbitration: candidates are i>=1 with ip & ie. The winner has max level, then max prio, then lowest id.
- Output register: if a winner exists and level > mintthresh, then meip=1, meid=id, mlevel=level, shv=shv[id]. Otherwise all outputs are 0.
- Latency: clic_irpt rising at edge E gives ip=1 at E+2 and clic_meip=1 at E+3. A bus write takes effect on the outputs 1 cycle after the write edge.
- Outputs update only through the output register. After an ack they drop or switch 2 cycles later.
- Reset asserted mid-transaction: the pending response is dropped, mem_ready=0 next cycle, and all state returns to reset values.

Test Plan:
- Reset, then read 0x0004 with NUM_IRQ=64, INTCTLBITS=8 -> rdata=0x01000040, mem_ready for 1 cycle, mem_error=0.
- Read 0x0800 -> mem_ready=1, mem_error=1, rdata=0. A write to 0x0800 leaves all registers unchanged.
- Irq 5 level mode, ie=1, ctl=0x80, nlbits=8; raise clic_irpt[5] at edge E -> meip=1, meid=5, mlevel=0x80 at E+3. Drop the line -> meip=0 three cycles later.
- Irq 3 and irq 7 both pending at level 0xC0 -> meid=3. Raise irq 7 ctl to 0xE0 -> meid=7.
- Irq 9 rising-edge mode, pending -> assert clic_ack with meid=9 -> ip[9]=0 and meip=0 two cycles later. If a new edge arrives in the same ack cycle, ip stays 1.
- mintthresh=0x80 with irq 4 level 0x80 pending -> meip=0. Set mintthresh=0x7F -> meip=1, meid=4.
